// File: rtl/cfs_md_pkg.sv
// Shared types and width helpers for the MD master and its command buffer.
package cfs_md_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRIVE = 1'b1
  } md_state_t;

  function automatic int offset_w(input int dw);
    return (dw <= 8) ? 1 : $clog2(dw / 8);
  endfunction

  function automatic int size_w(input int dw);
    return $clog2(dw / 8) + 1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/cfs_md_fifo.sv
// Command buffer: power-of-2 depth, wrap-bit pointers, head visible combinationally.
module cfs_md_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

  // Full and empty share the index bits and differ only in the wrap bit.
  assign empty     = (wr_ptr_reg == rd_ptr_reg);
  assign full      = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign level     = wr_ptr_reg - rd_ptr_reg;
  assign head_data = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/cfs_md_master.sv
// MD initiator: buffers legal commands, drives them out in order, reports completion and status counts.
module cfs_md_master
  import cfs_md_pkg::*;
#(
  parameter int ALGN_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH      = 4,
  localparam int OFFSET_W = offset_w(ALGN_DATA_WIDTH),
  localparam int SIZE_W   = size_w(ALGN_DATA_WIDTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [ALGN_DATA_WIDTH-1:0] cmd_data,
  input  logic [OFFSET_W-1:0]        cmd_offset,
  input  logic [SIZE_W-1:0]          cmd_size,
  output logic                       md_valid,
  output logic [ALGN_DATA_WIDTH-1:0] md_data,
  output logic [OFFSET_W-1:0]        md_offset,
  output logic [SIZE_W-1:0]          md_size,
  input  logic                       md_ready,
  input  logic                       md_err,
  output logic                       rsp_valid,
  output logic                       rsp_err,
  output logic [7:0]                 cnt_sent,
  output logic [7:0]                 cnt_err,
  output logic [7:0]                 cnt_drop
);

  localparam int ENTRY_W = ALGN_DATA_WIDTH + OFFSET_W + SIZE_W;
  localparam int LVL_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [SIZE_W:0] BYTES = (SIZE_W + 1)'(ALGN_DATA_WIDTH / 8);

  md_state_t          state_reg;
  logic               rsp_valid_reg;
  logic               rsp_err_reg;
  logic [7:0]         cnt_sent_reg;
  logic [7:0]         cnt_err_reg;
  logic [7:0]         cnt_drop_reg;

  logic [ENTRY_W-1:0] head_data;
  logic               fifo_full;
  logic               fifo_empty;
  logic [LVL_W-1:0]   fifo_level;
  logic [SIZE_W:0]    span;
  logic               legal;
  logic               handshake;
  logic               accept;
  logic               push;
  logic               drop;

  // One extra bit keeps offset+size from overflowing before the range compare.
  assign span  = {{(SIZE_W + 1 - OFFSET_W){1'b0}}, cmd_offset} + {1'b0, cmd_size};
  assign legal = (cmd_size != '0) && (span <= BYTES);

  assign md_valid  = (state_reg == ST_DRIVE);
  assign handshake = md_valid && md_ready;
  // A pop in the same cycle frees a slot, so a full buffer can still accept.
  assign cmd_ready = !reset && (!fifo_full || handshake);
  assign accept    = cmd_valid && cmd_ready;
  assign push      = accept && legal;
  assign drop      = accept && !legal;

  cfs_md_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data({cmd_data, cmd_offset, cmd_size}),
    .pop      (handshake),
    .head_data(head_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  assign {md_data, md_offset, md_size} = md_valid ? head_data : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
    end else begin
      rsp_valid_reg <= handshake;
      rsp_err_reg   <= handshake && md_err;
      case (state_reg)
        ST_IDLE:  if (push || !fifo_empty) state_reg <= ST_DRIVE;
        ST_DRIVE: if (handshake && !push && fifo_level == LVL_W'(1)) state_reg <= ST_IDLE;
        default:  state_reg <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_sent_reg <= '0;
      cnt_err_reg  <= '0;
      cnt_drop_reg <= '0;
    end else begin
      if (handshake)           cnt_sent_reg <= sat_inc8(cnt_sent_reg);
      if (handshake && md_err) cnt_err_reg  <= sat_inc8(cnt_err_reg);
      if (drop)                cnt_drop_reg <= sat_inc8(cnt_drop_reg);
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;
  assign cnt_sent  = cnt_sent_reg;
  assign cnt_err   = cnt_err_reg;
  assign cnt_drop  = cnt_drop_reg;

endmodule

// File: tb/tb_cfs_md_master.sv
// Directed and random checks of cfs_md_master against a queue-based reference model.
module tb_cfs_md_master;

  localparam int DW = 32;
  localparam int FD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_data = '0;
  logic [1:0]  cmd_offset = '0;
  logic [2:0]  cmd_size = '0;
  logic        md_valid;
  logic [31:0] md_data;
  logic [1:0]  md_offset;
  logic [2:0]  md_size;
  logic        md_ready = 1'b0;
  logic        md_err = 1'b0;
  logic        rsp_valid;
  logic        rsp_err;
  logic [7:0]  cnt_sent;
  logic [7:0]  cnt_err;
  logic [7:0]  cnt_drop;

  always #5 clk = ~clk;

  cfs_md_master #(.ALGN_DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_offset(cmd_offset), .cmd_size(cmd_size),
    .md_valid(md_valid), .md_data(md_data), .md_offset(md_offset), .md_size(md_size),
    .md_ready(md_ready), .md_err(md_err),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .cnt_sent(cnt_sent), .cnt_err(cnt_err), .cnt_drop(cnt_drop)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  o;
    logic [2:0]  s;
  } cmd_t;

  // Reference model: pending legal commands in order, plus expected counters.
  cmd_t q[$];
  int   m_sent, m_err, m_drop;
  logic m_rsp_v, m_rsp_e;
  int   tests_run = 0;
  int   tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic cmd_t mk(input logic [31:0] d, input logic [1:0] o, input logic [2:0] s);
    cmd_t c;
    c.d = d; c.o = o; c.s = s;
    return c;
  endfunction

  function automatic cmd_t rnd_legal();
    int s;
    s = $urandom_range(1, 4);
    return mk($urandom, 2'($urandom_range(0, 4 - s)), 3'(s));
  endfunction

  function automatic int sat(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  // One clock cycle: drive inputs, compare all outputs with the model, advance model.
  task automatic step(input logic v, input cmd_t c, input logic mr, input logic me);
    logic exp_ready, hs, legal;
    cmd_valid = v; cmd_data = c.d; cmd_offset = c.o; cmd_size = c.s;
    md_ready = mr; md_err = me;
    #1;
    hs        = (q.size() > 0) && mr;
    exp_ready = (q.size() < FD) || hs;
    check("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
    check("md_valid", 32'(md_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      check("md_data", md_data, q[0].d);
      check("md_offset", 32'(md_offset), 32'(q[0].o));
      check("md_size", 32'(md_size), 32'(q[0].s));
    end
    check("rsp_valid", 32'(rsp_valid), 32'(m_rsp_v));
    if (m_rsp_v) check("rsp_err", 32'(rsp_err), 32'(m_rsp_e));
    check("cnt_sent", 32'(cnt_sent), 32'(m_sent));
    check("cnt_err", 32'(cnt_err), 32'(m_err));
    check("cnt_drop", 32'(cnt_drop), 32'(m_drop));
    legal   = (c.s != 0) && (int'(c.o) + int'(c.s) <= DW / 8);
    m_rsp_v = hs;
    m_rsp_e = hs && me;
    if (hs) begin
      void'(q.pop_front());
      m_sent = sat(m_sent);
      if (me) m_err = sat(m_err);
    end
    if (v && exp_ready) begin
      if (legal) q.push_back(c);
      else       m_drop = sat(m_drop);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic mr);
    step(1'b0, mk('0, '0, '0), mr, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1; cmd_valid = 1'b0; md_ready = 1'b0; md_err = 1'b0;
    #1;
    check("rst_cmd_ready_pre", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    check("rst_md_valid", 32'(md_valid), 32'd0);
    check("rst_md_data", md_data, 32'd0);
    check("rst_md_offset", 32'(md_offset), 32'd0);
    check("rst_md_size", 32'(md_size), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_cnt_sent", 32'(cnt_sent), 32'd0);
    check("rst_cnt_err", 32'(cnt_err), 32'd0);
    check("rst_cnt_drop", 32'(cnt_drop), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    reset = 1'b0;
    q.delete();
    m_sent = 0; m_err = 0; m_drop = 0;
    m_rsp_v = 1'b0; m_rsp_e = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_t c;
    cmd_t cs[6];

    // Basic single transfer with md_ready tied high.
    do_reset();
    step(1'b1, mk(32'h11223344, 2'd0, 3'd4), 1'b1, 1'b0);
    check("s1_md_valid_rise", 32'(md_valid), 32'd1);
    check("s1_md_data", md_data, 32'h11223344);
    idle(1'b1);
    check("s1_rsp_valid", 32'(rsp_valid), 32'd1);
    check("s1_rsp_err", 32'(rsp_err), 32'd0);
    check("s1_cnt_sent", 32'(cnt_sent), 32'd1);
    idle(1'b1);

    // Backpressure: payload holds for six cycles, one handshake.
    do_reset();
    c = rnd_legal();
    step(1'b1, c, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("s2_hold_valid", 32'(md_valid), 32'd1);
      check("s2_hold_data", md_data, c.d);
      check("s2_hold_size", 32'(md_size), 32'(c.s));
      idle(1'b0);
    end
    idle(1'b1);
    idle(1'b0);
    check("s2_cnt_sent", 32'(cnt_sent), 32'd1);

    // Illegal commands are dropped and never reach the MD side.
    do_reset();
    step(1'b1, mk(32'hDEADBEEF, 2'd3, 3'd2), 1'b1, 1'b0);
    step(1'b1, mk(32'hCAFEF00D, 2'd0, 3'd0), 1'b1, 1'b0);
    check("s3_md_valid", 32'(md_valid), 32'd0);
    idle(1'b1);
    check("s3_cnt_drop", 32'(cnt_drop), 32'd2);
    check("s3_md_valid_late", 32'(md_valid), 32'd0);

    // Fill to full under backpressure, then drain back-to-back.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cs[i] = rnd_legal();
      step(1'b1, cs[i], 1'b0, 1'b0);
    end
    check("s4_cmd_ready_full", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("s4_drain_valid", 32'(md_valid), 32'd1);
      check("s4_drain_data", md_data, cs[i].d);
      idle(1'b1);
    end
    check("s4_md_valid_end", 32'(md_valid), 32'd0);
    check("s4_cnt_sent", 32'(cnt_sent), 32'd4);

    // Error reporting on the middle of three transfers, then saturation.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, rnd_legal(), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, mk('0, '0, '0), 1'b1, (i == 1));
      check("s5_rsp_valid", 32'(rsp_valid), 32'd1);
      check("s5_rsp_err", 32'(rsp_err), 32'(i == 1));
    end
    check("s5_cnt_err", 32'(cnt_err), 32'd1);
    for (int i = 0; i < 310; i++) step(1'b1, rnd_legal(), 1'b1, 1'b1);
    check("s5_cnt_err_sat", 32'(cnt_err), 32'd255);
    check("s5_cnt_sent_sat", 32'(cnt_sent), 32'd255);
    idle(1'b1);
    idle(1'b1);

    // Reset while driving with md_ready low abandons the transfer.
    do_reset();
    step(1'b1, rnd_legal(), 1'b1, 1'b0);
    step(1'b1, rnd_legal(), 1'b1, 1'b1);
    step(1'b1, rnd_legal(), 1'b0, 1'b0);
    check("s6_in_drive", 32'(md_valid), 32'd1);
    do_reset();
    check("s6_no_rsp", 32'(rsp_valid), 32'd0);
    idle(1'b1);
    idle(1'b1);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      c = ($urandom_range(0, 3) == 0) ? mk($urandom, 2'($urandom), 3'($urandom)) : rnd_legal();
      step(($urandom_range(0, 3) != 0), c, ($urandom_range(0, 2) != 0), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
